// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared widths, image limit and loader state encoding
package boot_loader_pkg;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int MAX_WORDS  = 64;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;
endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-stream input, memory write port and CPU control of the loader
interface boot_loader_if;
    import boot_loader_pkg::*;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  restart;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  err;
    modport master (
        output in_valid, in_data, restart,
        input  in_ready, mem_write, mem_addr, mem_wdata, cpu_hold, done, err
    );
    modport slave (
        input  in_valid, in_data, restart,
        output in_ready, mem_write, mem_addr, mem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/boot_loader_packer.sv
// boot_loader_packer: big-endian byte-to-word shift register with a 2-bit byte count
module boot_loader_packer
    import boot_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  shift_en,
    input  logic                  clear,
    input  logic [7:0]            byte_in,
    output logic [DATA_WIDTH-1:0] word_out,
    output logic                  full
);
    logic [1:0] byte_cnt;

    assign full = shift_en && (byte_cnt == 2'd3);

    // shift each accepted byte in from the bottom so the first byte ends up in the top lane
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            word_out <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word_out <= {word_out[DATA_WIDTH-9:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a length-prefixed byte image into memory and then releases the CPU
module boot_loader
    import boot_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    boot_loader_if.slave bus
);
    state_t                state, next;
    logic [7:0]            n_q, word_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  mem_write_q, done_q, err_q, hold_q;
    logic                  xfer, full, rearm;
    logic [DATA_WIDTH-1:0] word;

    assign bus.in_ready  = reset && (state == IDLE || state == LOAD);
    assign xfer          = bus.in_valid && bus.in_ready;
    assign rearm         = bus.restart && (state == DONE || state == ERR);
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = word;
    assign bus.cpu_hold  = hold_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    boot_loader_packer u_packer (
        .clock    (clock),
        .reset    (reset),
        .shift_en (xfer && state == LOAD),
        .clear    (rearm),
        .byte_in  (bus.in_data),
        .word_out (word),
        .full     (full)
    );

    // next-state decode: length byte in IDLE, four data bytes per word, one write cycle each
    always_comb begin
        next = state;
        case (state)
            IDLE:     if (xfer) next = (bus.in_data == 8'd0) ? DONE :
                                       (bus.in_data > 8'(MAX_WORDS)) ? ERR : LOAD;
            LOAD:     if (full) next = WRITE;
            WRITE:    next = (word_cnt + 8'd1 == n_q) ? DONE : LOAD;
            DONE,
            ERR:      if (bus.restart) next = IDLE;
            default:  next = IDLE;
        endcase
    end

    // state, counters and outputs; outputs are registered from the next state
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            n_q         <= '0;
            word_cnt    <= '0;
            addr_q      <= '0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= 1'b1;
        end else begin
            state       <= next;
            mem_write_q <= next == WRITE;
            done_q      <= next == DONE;
            err_q       <= next == ERR;
            hold_q      <= next != DONE;
            if (state == IDLE && xfer) n_q <= bus.in_data;
            if (state == WRITE) begin
                word_cnt <= word_cnt + 8'd1;
                addr_q   <= addr_q + ADDR_WIDTH'(4);
            end else if (rearm) begin
                word_cnt <= '0;
                addr_q   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed and randomized image loads checked against an image-level write model
module tb_boot_loader;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wr = 0;
    int done_cyc = 0;
    int hold_falls = 0;
    logic prev_hold = 1'b1;
    logic prev_done = 1'b0;
    logic [39:0] wq[$];
    logic [7:0] img[$];

    boot_loader_if bus ();
    boot_loader dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // observe the memory port and status lines half a cycle after each edge
    always @(negedge clock) begin
        cyc++;
        if (bus.mem_write) begin
            wq.push_back({bus.mem_addr, bus.mem_wdata});
            last_wr = cyc;
        end
        if (prev_hold && !bus.cpu_hold) hold_falls++;
        if (bus.done && !prev_done) done_cyc = cyc;
        prev_hold = bus.cpu_hold;
        prev_done = bus.done;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.restart = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_status", {28'd0, bus.mem_write, bus.cpu_hold, bus.done, bus.err}, 32'b0100);
        chk("rst_addr", {24'd0, bus.mem_addr}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic send(logic [7:0] b, int gap);
        int t = 0;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_data = b;
        while (!bus.in_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (t == 20) chk("send_timeout", 32'(t), 32'd0);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(bus.done || bus.err) && t < 400) begin
            @(negedge clock);
            t++;
        end
        if (t == 400) chk("end_timeout", 32'(t), 32'd0);
        @(negedge clock);
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(negedge clock);
        bus.restart = 1'b0;
    endtask

    // model: image byte 0 is the word count, valid counts produce words at 4*i from address 0
    task automatic compare_writes(string tag);
        int n = int'(img[0]);
        int nw = (n > 64) ? 0 : n;
        logic [39:0] e;
        chk({tag, "_count"}, 32'(wq.size()), 32'(nw));
        for (int w = 0; w < nw && w < wq.size(); w++) begin
            e = {8'(w * 4), img[1 + 4 * w], img[2 + 4 * w], img[3 + 4 * w], img[4 + 4 * w]};
            chk({tag, "_addr"}, {24'd0, wq[w][39:32]}, {24'd0, e[39:32]});
            chk({tag, "_data"}, wq[w][31:0], e[31:0]);
        end
    endtask

    task automatic run(int gapmax);
        wq.delete();
        foreach (img[i]) send(img[i], $urandom_range(0, gapmax));
        wait_end();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.restart = 1'b0;
        reset_dut();

        img = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        run(0);
        compare_writes("two_words");
        chk("two_done_lat", 32'(done_cyc - last_wr), 32'd1);
        chk("two_status", {29'd0, bus.cpu_hold, bus.done, bus.in_ready}, 32'b010);

        reset_dut();
        img = '{8'h00};
        wq.delete();
        send(8'h00, 0);
        chk("zero_done", {30'd0, bus.done, bus.cpu_hold}, 32'b10);
        @(negedge clock);
        chk("zero_in_ready", {31'd0, bus.in_ready}, 32'd0);
        compare_writes("zero");

        reset_dut();
        img = '{8'h41};
        wq.delete();
        send(8'h41, 0);
        repeat (3) @(negedge clock);
        chk("err_status", {29'd0, bus.err, bus.cpu_hold, bus.in_ready}, 32'b110);
        compare_writes("err");
        pulse_restart();
        chk("err_restart", {29'd0, bus.err, bus.done, bus.in_ready}, 32'b001);

        reset_dut();
        img = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        wq.delete();
        send(8'h01, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        begin
            int low = 0;
            for (int i = 0; i < 20; i++) begin
                bus.restart = (i == 5);
                @(negedge clock);
                if (!bus.in_ready) low++;
            end
            bus.restart = 1'b0;
            chk("stall_ready", 32'(low), 32'd0);
        end
        send(8'hCC, 0);
        send(8'hDD, 0);
        wait_end();
        compare_writes("stall");

        reset_dut();
        wq.delete();
        foreach (img[i]) ;
        img = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        foreach (img[i]) send(img[i], 0);
        repeat (2) @(negedge clock);
        chk("midrst_count", 32'(wq.size()), 32'd1);
        chk("midrst_word", wq.size() > 0 ? wq[0][31:0] : 32'hX, 32'h11223344);
        reset_dut();
        img = '{8'h01, 8'h77, 8'h88, 8'h99, 8'hAA};
        run(0);
        compare_writes("after_rst");

        reset_dut();
        hold_falls = 0;
        img = '{8'd64};
        for (int k = 0; k < 256; k++) img.push_back(8'(k));
        run(0);
        compare_writes("full");
        chk("full_last_addr", wq.size() == 64 ? {24'd0, wq[63][39:32]} : 32'hX, 32'hFC);
        chk("full_done", {31'd0, bus.done}, 32'd1);
        chk("full_hold_falls", 32'(hold_falls), 32'd1);

        for (int it = 0; it < 8; it++) begin
            int n = ($urandom_range(0, 3) == 0) ? $urandom_range(65, 255) : $urandom_range(0, 6);
            pulse_restart();
            chk("rnd_rearm", {28'd0, bus.in_ready, bus.cpu_hold, bus.done, bus.err}, 32'b1100);
            img = '{8'(n)};
            if (n <= 64) for (int k = 0; k < 4 * n; k++) img.push_back(8'($urandom));
            run(2);
            compare_writes("rnd");
            chk("rnd_end", {30'd0, bus.done, bus.err}, n > 64 ? 32'b01 : 32'b10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
